// File: rtl/u_ns_add16_pkg.sv
// Shared definitions for the unary non-scaled 16-input adder.
//   NUM_IN_DEF : default number of unary input streams
//   ACC_W_DEF  : default backlog accumulator width
//   sat_add()  : backlog update (acc + inc - dec), clamped to a maximum
package u_ns_add16_pkg;

  localparam int NUM_IN_DEF = 16;
  localparam int ACC_W_DEF  = 10;

  // The caller guarantees dec is only set when acc + inc is non-zero,
  // so the subtraction never wraps.
  function automatic int unsigned sat_add(input int unsigned acc,
                                          input int unsigned inc,
                                          input logic        dec,
                                          input int unsigned max_v);
    int unsigned sum;
    sum = acc + inc - 32'(dec);
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/u_ns_add16_if.sv
// Stream bundle for the unary adder.
//   in  : one bit per unary input stream, driven by the producer
//   out : merged unary output stream, driven by the adder
// Modports: master = stream producer/consumer side, slave = adder side.
interface u_ns_add16_if #(
  parameter int NUM_IN = u_ns_add16_pkg::NUM_IN_DEF
) ();

  logic [NUM_IN-1:0] in;
  logic              out;

  modport master (output in, input out);
  modport slave  (input in, output out);

endinterface

// File: rtl/u_ns_add16_popcount16.sv
// Combinational population count of the unary input bits.
//   bits : NUM_IN input bits
//   cnt  : number of ones in bits, $clog2(NUM_IN+1) bits wide
// The 16-input case is an explicit balanced adder tree; other widths fall
// back to a linear sum that synthesis rebalances.
module u_ns_add16_popcount16 #(
  parameter int NUM_IN = u_ns_add16_pkg::NUM_IN_DEF,
  parameter int CNT_W  = $clog2(NUM_IN + 1)
) (
  input  logic [NUM_IN-1:0] bits,
  output logic [CNT_W-1:0]  cnt
);

  if (NUM_IN == 16) begin : g_tree
    logic [1:0] s1 [8];
    logic [2:0] s2 [4];
    logic [3:0] s3 [2];

    always_comb begin
      for (int i = 0; i < 8; i++) s1[i] = {1'b0, bits[2*i]} + {1'b0, bits[2*i+1]};
      for (int i = 0; i < 4; i++) s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
      for (int i = 0; i < 2; i++) s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
      cnt = {1'b0, s3[0]} + {1'b0, s3[1]};
    end
  end else begin : g_linear
    always_comb begin
      // NOTE: give every always_comb output a value before any conditional
      // or loop update, otherwise a latch is inferred.
      cnt = '0;
      for (int i = 0; i < NUM_IN; i++) cnt = cnt + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/u_ns_add16.sv
// Unary non-scaled adder: merges NUM_IN rate-coded bitstreams into one
// without 1/NUM_IN scaling. Ones arriving faster than one per cycle are
// held in a saturating backlog and emitted later, one per cycle.
//   clk : rising-edge clock
//   rst : synchronous reset, active-high; clears backlog and output
//   bus : slave side of u_ns_add16_if (bus.in sampled, bus.out registered)
module u_ns_add16
  import u_ns_add16_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  u_ns_add16_if.slave   bus
);

  localparam int          CNT_W   = $clog2(NUM_IN + 1);
  localparam int unsigned ACC_MAX = (32'd1 << ACC_W) - 32'd1;

  logic [CNT_W-1:0] cnt;
  logic [ACC_W:0]   total;   // one extra bit so acc + cnt never wraps
  logic             emit;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] acc;
  logic             out_q;

  u_ns_add16_popcount16 #(
    .NUM_IN (NUM_IN),
    .CNT_W  (CNT_W)
  ) u_popcount (
    .bits (bus.in),
    .cnt  (cnt)
  );

  always_comb begin
    total   = {1'b0, acc} + (ACC_W + 1)'(cnt);
    emit    = (total != '0);
    // Excess beyond ACC_MAX is discarded, not wrapped.
    acc_nxt = ACC_W'(sat_add(32'(acc), 32'(cnt), emit, ACC_MAX));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      acc   <= '0;
      out_q <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      out_q <= emit;
    end
  end

  // Output comes straight from a flop: no combinational path from in.
  assign bus.out = out_q;

endmodule

// File: tb/tb_u_ns_add16.sv
// Self-checking bench for u_ns_add16. Each driven cycle pushes the reference
// model's expected {out, acc} into a scoreboard queue; the entry is popped
// and compared once the DUT has taken the corresponding clock edge.
module tb_u_ns_add16;

  localparam int unsigned MAX_ACC = 1023;

  typedef struct {
    logic        out;
    int unsigned acc;
  } exp_t;

  logic clk;
  logic rst;

  u_ns_add16_if bus ();

  u_ns_add16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          total_cnt = 0;
  int          bad_cnt   = 0;
  int unsigned m_acc     = 0;
  longint      dropped   = 0;
  longint      ones_in   = 0;
  longint      ones_out  = 0;

  task automatic check(input string tag, input int unsigned got,
                       input int unsigned exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle (called just after a falling edge), updates the model,
  // then compares at the next falling edge. Returns the observed output.
  task automatic cycle(input logic r, input logic [15:0] v, output logic o);
    exp_t        e;
    int unsigned raw;
    logic        em;
    rst    = r;
    bus.in = v;
    if (r) begin
      m_acc = 0;
      em    = 1'b0;
    end else begin
      raw = m_acc + $countones(v);
      em  = (raw != 0);
      raw = raw - (em ? 1 : 0);
      if (raw > MAX_ACC) begin
        dropped += raw - MAX_ACC;
        raw = MAX_ACC;
      end
      m_acc = raw;
      ones_in += $countones(v);
    end
    e.out = em;
    e.acc = m_acc;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("out", 32'(bus.out), 32'(e.out));
    check("acc", 32'(dut.acc), e.acc);
    o = bus.out;
    if (!r && bus.out === 1'b1) ones_out++;
  endtask

  // Drive zeros for n cycles; count output ones and report the last output.
  task automatic drain(input int n, output int ones, output logic last);
    logic o;
    ones = 0;
    last = 1'b0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 16'h0000, o);
      if (o === 1'b1) ones++;
      last = o;
    end
  endtask

  initial begin
    logic o;
    int   n;
    rst    = 1'b1;
    bus.in = 16'hFFFF;

    // Reset holds everything at zero even with all inputs active.
    cycle(1'b1, 16'hFFFF, o);
    cycle(1'b1, 16'hFFFF, o);
    check("rst_out", 32'(o), 0);
    cycle(1'b0, 16'hFFFF, o);
    check("first_out", 32'(o), 1);
    check("first_acc", 32'(dut.acc), 15);

    // Burst then drain.
    cycle(1'b1, 16'h0000, o);
    for (int i = 0; i < 2; i++)  cycle(1'b0, 16'hFFFF, o);
    check("burst_acc1", 32'(dut.acc), 30);
    for (int i = 0; i < 10; i++) cycle(1'b0, 16'hFF00, o);
    check("burst_acc2", 32'(dut.acc), 100);
    for (int i = 0; i < 10; i++) cycle(1'b0, 16'hF000, o);
    check("burst_acc3", 32'(dut.acc), 130);
    drain(140, n, o);
    check("drain_ones", 32'(n), 130);
    check("drain_last", 32'(o), 0);

    // Single stream on alternate cycles: out mirrors in one cycle late.
    cycle(1'b1, 16'h0000, o);
    for (int i = 0; i < 20; i++) cycle(1'b0, (i % 2 == 0) ? 16'h0001 : 16'h0000, o);
    check("single_acc", 32'(dut.acc), 0);

    // Constant single one: acc holds, out stays high.
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0100, o);
    check("steady_out", 32'(o), 1);

    // Saturation and full drain.
    cycle(1'b1, 16'h0000, o);
    for (int i = 0; i < 80; i++) cycle(1'b0, 16'hFFFF, o);
    check("sat_acc", 32'(dut.acc), 1023);
    check("sat_out", 32'(o), 1);
    drain(1030, n, o);
    check("sat_drain_ones", 32'(n), 1023);
    check("sat_drain_last", 32'(o), 0);

    // Reset mid-operation discards backlog.
    cycle(1'b1, 16'h0000, o);
    for (int i = 0; i < 2; i++)  cycle(1'b0, 16'hFFFF, o);
    for (int i = 0; i < 10; i++) cycle(1'b0, 16'hFF00, o);
    check("mid_acc", 32'(dut.acc), 100);
    cycle(1'b1, 16'hFFFF, o);
    check("mid_rst_out", 32'(o), 0);
    drain(5, n, o);
    check("mid_drain_ones", 32'(n), 0);

    // Random traffic, then drain; ones conserved except saturation losses.
    cycle(1'b1, 16'h0000, o);
    ones_in  = 0;
    ones_out = 0;
    dropped  = 0;
    for (int i = 0; i < 5000; i++) begin
      logic [15:0] v;
      v = 16'($urandom) & 16'($urandom);
      cycle(1'b0, v, o);
    end
    drain(1100, n, o);
    check("rand_drain_last", 32'(o), 0);
    check("rand_conserve", 32'(ones_out), 32'(ones_in - dropped));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
